// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - THR write port and TX FIFO status bundle for uart_tx_fifo
interface uart_tx_fifo_if #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16
);
   logic                          wr_en;
   logic [DATA_W-1:0]             wr_data;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic [$clog2(FIFO_DEPTH):0]   fifo_level;
   logic                          overflow;
   logic                          TXRDYn;

   modport master (
      output wr_en, wr_data,
      input  fifo_full, fifo_empty, fifo_level, overflow, TXRDYn
   );

   modport slave (
      input  wr_en, wr_data,
      output fifo_full, fifo_empty, fifo_level, overflow, TXRDYn
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - TX FIFO plus oversampled UART serialiser; UART_TX_BREAK_EN enables break_ctrl masking
module uart_tx_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int OVERSAMPLE = 16
) (
   input  logic          PCLK,
   input  logic          PRESET,
   input  logic          baud_tick,
   uart_tx_fifo_if.slave wr_if,
   input  logic [1:0]    word_length,
   input  logic          parity_en,
   input  logic          even_parity,
   input  logic          stick_parity,
   input  logic          two_stop,
   input  logic          break_ctrl,
   output logic          sout,
   output logic          tx_busy,
   output logic          tx_empty,
   output logic          frame_done
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(2 * OVERSAMPLE);
   localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
   localparam logic [TW-1:0] TC_ONE   = TW'(1);
   localparam logic [TW-1:0] BIT_LAST = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr, level;
   logic              full, empty, push, pop;
   logic              ovf_q, txrdy_hold;

   state_t            state, state_nx;
   logic [TW-1:0]     tc, sh_stop_last, stop_now;
   logic [2:0]        bc;
   logic [DATA_W-1:0] shr, head;
   logic [3:0]        sh_len, len_now;
   logic              sh_par_en, sh_par_bit, par_now, par_x;
   logic              bit_end, stop_end, load, fsm_sout;

   assign level = wr_ptr - rd_ptr;
   assign full  = (level == (AW+1)'(FIFO_DEPTH));
   assign empty = (level == '0);
   assign push  = wr_if.wr_en & ~full;
   assign pop   = load;
   assign head  = mem[rd_ptr[AW-1:0]];

   assign wr_if.fifo_full  = full;
   assign wr_if.fifo_empty = empty;
   assign wr_if.fifo_level = level;
   assign wr_if.overflow   = ovf_q;
   assign wr_if.TXRDYn     = ~empty & (full | txrdy_hold);
   assign tx_empty         = empty & ~tx_busy;

   // FIFO pointers, overflow pulse and DMA request hysteresis
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         ovf_q      <= 1'b0;
         txrdy_hold <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         ovf_q <= wr_if.wr_en & full;
         if (empty)     txrdy_hold <= 1'b0;
         else if (full) txrdy_hold <= 1'b1;
      end
   end

   // FIFO storage, no reset needed since pointers gate every read
   always_ff @(posedge PCLK) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_if.wr_data;
   end

   // frame config as it would be latched from the live LCR fields and FIFO head
   always_comb begin
      len_now = 4'd5 + {2'b00, word_length};
      if (len_now > 4'(DATA_W)) len_now = 4'(DATA_W);
      par_x = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         if (4'(i) < len_now) par_x = par_x ^ head[i];
      end
      par_now = stick_parity ? ~even_parity : (par_x ^ ~even_parity);
      if (!two_stop)                 stop_now = BIT_LAST;
      else if (word_length == 2'b00) stop_now = TW'(3 * OVERSAMPLE / 2 - 1);
      else                           stop_now = TW'(2 * OVERSAMPLE - 1);
   end

   assign bit_end  = baud_tick & (tc == BIT_LAST);
   assign stop_end = baud_tick & (tc == sh_stop_last);

   // state register
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state <= IDLE;
      else        state <= state_nx;
   end

   // next-state decode
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   if (baud_tick && !empty) state_nx = START;
         START:  if (bit_end) state_nx = DATA;
         DATA:   if (bit_end && bc == 3'(sh_len - 4'd1))
                    state_nx = sh_par_en ? PARITY : STOP;
         PARITY: if (bit_end) state_nx = STOP;
         STOP:   if (stop_end) state_nx = empty ? IDLE : START;
         default: state_nx = IDLE;
      endcase
   end

   // outputs and FIFO pop; a pop also loads the frame shadow
   always_comb begin
      fsm_sout   = 1'b1;
      tx_busy    = 1'b1;
      frame_done = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            tx_busy = 1'b0;
            load    = baud_tick & ~empty;
         end
         START:  fsm_sout = 1'b0;
         DATA:   fsm_sout = shr[0];
         PARITY: fsm_sout = sh_par_bit;
         STOP: begin
            frame_done = stop_end;
            load       = stop_end & ~empty;
         end
         default: ;
      endcase
   end

   // tick/bit counters, shift register and per-frame config shadow
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         tc           <= '0;
         bc           <= '0;
         shr          <= '0;
         sh_len       <= '0;
         sh_par_en    <= 1'b0;
         sh_par_bit   <= 1'b0;
         sh_stop_last <= '0;
      end else if (load) begin
         tc           <= '0;
         bc           <= '0;
         shr          <= head;
         sh_len       <= len_now;
         sh_par_en    <= parity_en;
         sh_par_bit   <= par_now;
         sh_stop_last <= stop_now;
      end else if (baud_tick && state != IDLE) begin
         if (state_nx != state || (state == DATA && bit_end)) tc <= '0;
         else                                                 tc <= tc + TC_ONE;
         if (state == DATA && bit_end) begin
            shr <= shr >> 1;
            bc  <= bc + 3'd1;
         end
      end
   end

`ifdef UART_TX_BREAK_EN
   logic break_q;

   // break request registered so the line drops on the following PCLK
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) break_q <= 1'b0;
      else        break_q <= break_ctrl;
   end

   assign sout = fsm_sout & ~break_q;
`else
   logic unused_break;
   assign unused_break = break_ctrl;
   assign sout         = fsm_sout;
`endif
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised successor to the single-byte UART transmitter: TX FIFO plus a serialiser running on the PCLK domain, gated by the 16x baud tick from baud_gen. It no longer uses a derived baud clock.
- Sits between the APB register file (LCR fields, THR writes) and UART_SOUT.
- Adds buffering, programmable word length, stick parity and 1/1.5/2 stop bits, plus DMA-ready signalling.

Parameters:
- DATA_W, 8, maximum data bits per frame; legal range 5..8.
- FIFO_DEPTH, 16, TX FIFO entries; must be a power of 2, at least 2.
- OVERSAMPLE, 16, baud_tick pulses per serial bit time.

Ports:
- PCLK  in  1  system clock
- PRESET  in  1  asynchronous active-high reset
- baud_tick  in  1  one-PCLK pulse at OVERSAMPLE x baud rate
- wr_en  in  1  push wr_data into FIFO (THR write)
- wr_data  in  DATA_W  character to transmit (LSB first)
- word_length  in  2  00=5, 01=6, 10=7, 11=8 data bits
- parity_en  in  1  insert parity bit
- even_parity  in  1  1=even, 0=odd
- stick_parity  in  1  parity bit forced to ~even_parity when parity_en
- two_stop  in  1  0=1 stop; 1=2 stop (1.5 when word_length=00)
- break_ctrl  in  1  force line low (macro-dependent)
- sout  out  1  serial output
- fifo_full  out  1  FIFO full
- fifo_empty  out  1  FIFO empty (LSR THRE)
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
- tx_busy  out  1  frame in progress
- tx_empty  out  1  fifo_empty and not tx_busy (LSR TEMT)
- overflow  out  1  one-cycle pulse on write while full
- frame_done  out  1  one-cycle pulse at end of last stop bit
- TXRDYn  out  1  DMA request, active low

Behaviour:
- Reset values: sout=1, fifo_empty=1, tx_empty=1, TXRDYn=0. All other outputs are 0; FIFO pointers are cleared.
- FIFO: synchronous write and read; fifo_level = write count minus read count.
  - Write while full is dropped and pulses overflow, even if a pop occurs in the same cycle.
  - A simultaneous push and pop when not full leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - Tick counter tc counts baud_tick pulses within a bit; bit counter bc counts data bits.
- IDLE -> START: on a baud_tick while the FIFO is non-empty.
  - The head entry is popped and config is latched (word_length, parity, two_stop) into a frame shadow.
  - sout=0 from the next PCLK.
  - Config changes mid-frame take effect on the next frame only.
- START -> DATA: after OVERSAMPLE ticks. Data bits are shifted out LSB first, each for OVERSAMPLE ticks; bits above word_length are ignored.
- DATA -> PARITY if parity_en, else DATA -> STOP.
  - Parity bit = XOR of sent data bits, inverted when odd.
  - With stick_parity, parity bit = ~even_parity.
- STOP: sout=1 for OVERSAMPLE ticks (1 stop), 3*OVERSAMPLE/2 (1.5 stop) or 2*OVERSAMPLE (2 stop).
  - At the end, frame_done pulses for one cycle.
  - If the FIFO is non-empty at that same tick, go directly to START (back-to-back frames, no idle gap); else go to IDLE.
- tx_busy=1 in every state except IDLE.
- TXRDYn=0 when fifo_empty. It goes to 1 when the FIFO becomes full and stays 1 until the FIFO is empty again (16550 mode-1 hysteresis).
- baud_tick with wr_en into an empty FIFO in the same cycle: no frame starts that tick; the frame starts on the next tick.
- Reset asserted mid-frame: sout returns to 1 immediately and FIFO contents are discarded.

Optional Feature:
- Macro UART_TX_BREAK_EN.
- Defined: while break_ctrl=1, sout is forced to 0 regardless of state. The FSM and FIFO keep running; the serialiser output is merely masked.
- Not defined: break_ctrl is ignored (port kept, unconnected internally); sout is driven by the FSM only.

Test Plan:
- OVERSAMPLE=16, tick every PCLK, word_length=11, no parity, 1 stop, write 0xA5 -> sout: 0, then 1,0,1,0,0,1,0,1, then 1. Each bit is 16 cycles; frame_done at cycle 160 after start.
- word_length=00, parity_en=1, even_parity=0, two_stop=1, write 0x13 -> sout: start, bits 1,1,0,0,1, parity 0, stop high for 24 ticks.
- Write FIFO_DEPTH+1 bytes with no ticks -> fifo_full=1, fifo_level=16, one overflow pulse, TXRDYn=1. Then drain all -> exactly 16 frames back-to-back with no idle ticks; tx_empty=1 after the last frame_done.
- stick_parity=1, even_parity=1, write 0xFF -> parity bit 0; with even_parity=0 -> parity bit 1.
- Change word_length from 11 to 10 mid-frame -> current frame still sends 8 bits; the next frame sends 7.
- With UART_TX_BREAK_EN: assert break_ctrl mid-DATA -> sout=0 from the next cycle, FSM still completes. Without the macro: sout is unaffected. PRESET mid-frame -> sout=1 and fifo_empty=1 in both builds.
